input_loader: RTL and testbench
===============================

// Module: input_loader
// PURPOSE
// - Upstream feeder of input_buffer. Accepts a valid/ready stream of narrow input elements (e.g. 8-bit pixels).
// - Packs PACK consecutive elements into one DATA_WIDTH buffer word.
// - Drives the buffer write port (wr_en/wr_addr/wr_data) with sequential addresses from a programmed base.
// - Runs one frame of num_words words per start command and reports completion with a one-cycle done pulse.
// PARAMETERS
// - LD_DATA_WIDTH  default DATA_WIDTH  : buffer word width, must equal input_buffer BUFFER_DATA_WIDTH
// - LD_ADDR_WIDTH  default ADDR_WIDTH  : buffer address width
// - IN_WIDTH       default 8           : stream element width; LD_DATA_WIDTH % IN_WIDTH == 0 (elaboration-time check)
// - PACK           localparam          : LD_DATA_WIDTH/IN_WIDTH elements per word; PACK==1 is legal (pass-through)
// PORTS
// - clk        in   1                 : clock
// - rst_n      in   1                 : reset, asynchronous, active-low
// - start      in   1                 : begin a frame; sampled only in IDLE
// - abort      in   1                 : cancel the frame in progress
// - base_addr  in   LD_ADDR_WIDTH     : first buffer address, latched on start
// - num_words  in   LD_ADDR_WIDTH+1   : words in the frame, latched on start
// - s_valid    in   1                 : stream element valid
// - s_ready    out  1                 : stream element ready
// - s_data     in   IN_WIDTH          : stream element
// - wr_en      out  1                 : buffer write strobe
// - wr_addr    out  LD_ADDR_WIDTH     : buffer write address
// - wr_data    out  LD_DATA_WIDTH     : buffer write word
// - busy       out  1                 : frame in progress
// - done       out  1                 : one-cycle pulse, frame complete
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; lane count, word counter, address and pack register cleared.
// - Reset asserted mid-frame drops any pending write and partial word.
// - wr_en, wr_addr, wr_data and done are registered outputs. s_ready and busy decode from state.
// - State IDLE: s_ready=0, busy=0.
//   - start with num_words!=0: latch base_addr and num_words; go to LOAD.
//   - start with num_words==0: done=1 on the next cycle; stay in IDLE; no writes.
// - State LOAD: s_ready=1, busy=1.
//   - Element acceptance: s_valid && s_ready. Each accepted element fills the next lane, lane 0 first.
//   - Lane 0 maps to wr_data[IN_WIDTH-1:0] (little-endian within the word).
//   - Accept in lane PACK-1 -> next cycle: wr_en=1, wr_addr=current address, wr_data=assembled word.
//   - On that same accept: address+1 (mod 2^LD_ADDR_WIDTH, wraps silently), words_left-1, lane count back to 0.
//   - Latency: 1 cycle from the final lane's accept to wr_en. Full throughput: 1 element per cycle, no bubbles between words.
//   - Final lane of the final word accepted -> go to LAST; s_ready falls the next cycle.
// - State LAST: busy=1, s_ready=0.
//   - wr_en=1 (final word) and done=1 in the same cycle; then return to IDLE.
// - start while busy: ignored, no error.
// - abort in LOAD: next cycle -> IDLE. Partial word discarded; no wr_en, no done.
//   - A wr_en already registered for a completed word is still presented.
//   - abort together with a valid accept: the element is not consumed (s_ready forced to 0 that cycle).
// - abort in LAST: ignored (the final write completes).
// - abort in IDLE: no effect.
// - s_valid while s_ready=0: element held by the source; the loader never drops stream data.
// STRUCTURE
// - Package input_loader_pkg:
//   - typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_LAST} ld_state_e
//   - lane-count width function: $clog2(PACK) clamped to a minimum of 1
// - Widths come from GLOBAL_PARAMS.vh (DATA_WIDTH, ADDR_WIDTH).
// - One sub-module, lane_packer:
//   - shift/lane register plus lane counter
//   - inputs: push, clear, elem
//   - outputs: word, word_done
// - FSM, address counter and word counter stay in input_loader.
// TESTING
// - DATA=32, IN=8, base=0x10, num_words=2, elements 0x01..0x08 back-to-back ->
//   writes 0x04030201@0x10, then 0x08070605@0x11 with done in the same cycle.
// - Same frame with s_valid toggling every other cycle ->
//   identical writes; wr_en only 1 cycle after each 4th accept.
// - base=max address (all ones), num_words=2 -> second write at address 0 (wrap-around).
// - num_words=0 start -> done pulse next cycle; s_ready, busy and wr_en stay 0.
// - abort after 6 of 8 elements -> one write only (first word); no done; s_ready=0 next cycle;
//   a new start then runs a clean frame from lane 0.
// - rst_n pulsed low mid-frame (after 3 elements) -> all outputs 0 immediately;
//   after release, IDLE with no spurious wr_en.

Source files
------------

// File: rtl/input_loader_pkg.sv
// Shared types and widths for the input loader slice.
// Codebase-wide buffer widths live here so every file sees the same values.
package input_loader_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_LAST
    } ld_state_e;

    // A single-lane word still needs a one-bit counter to stay a legal vector.
    function automatic int unsigned lane_cnt_width(input int unsigned pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

endpackage

// File: rtl/input_loader_if.sv
// Valid/ready element stream feeding the loader.
interface input_loader_if #(
    parameter int unsigned IN_WIDTH = 8
);
    logic                s_valid;
    logic                s_ready;
    logic [IN_WIDTH-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/input_loader_lane_packer.sv
// Assembles PACK narrow elements into one word, lane 0 in the low bits.
module lane_packer #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned PACK     = 4,
    parameter int unsigned LANE_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     clear,
    input  logic [IN_WIDTH-1:0]      elem,
    output logic [PACK*IN_WIDTH-1:0] word,
    output logic                     word_done
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

    logic [PACK-1:0][IN_WIDTH-1:0] lanes_q, lanes_d;
    logic [LANE_W-1:0]             lane_q,  lane_d;

    // The word presented includes the element being pushed this cycle, so the
    // final lane never has to round-trip through the register.
    always_comb begin
        lanes_d         = lanes_q;
        lanes_d[lane_q] = elem;
        word            = lanes_d;
        word_done       = push && (lane_q == LAST_LANE);
        lane_d          = lane_q;
        if (clear) begin
            lane_d = '0;
        end else if (push) begin
            lane_d = word_done ? '0 : lane_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q <= '0;
            lane_q  <= '0;
        end else begin
            lane_q <= lane_d;
            if (clear) begin
                lanes_q <= '0;
            end else if (push) begin
                lanes_q <= lanes_d;
            end
        end
    end

endmodule

// File: rtl/input_loader.sv
// Packs a stream of narrow elements into buffer words and writes one frame
// of num_words words at sequential addresses from base_addr.
module input_loader
    import input_loader_pkg::*;
#(
    parameter int unsigned LD_DATA_WIDTH = DATA_WIDTH,
    parameter int unsigned LD_ADDR_WIDTH = ADDR_WIDTH,
    parameter int unsigned IN_WIDTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [LD_ADDR_WIDTH-1:0] base_addr,
    input  logic [LD_ADDR_WIDTH:0]   num_words,
    input_loader_if.slave            s,
    output logic                     wr_en,
    output logic [LD_ADDR_WIDTH-1:0] wr_addr,
    output logic [LD_DATA_WIDTH-1:0] wr_data,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned PACK   = LD_DATA_WIDTH / IN_WIDTH;
    localparam int unsigned LANE_W = lane_cnt_width(PACK);
    localparam logic [LD_ADDR_WIDTH:0] ONE_WORD = (LD_ADDR_WIDTH + 1)'(1);

    if (LD_DATA_WIDTH % IN_WIDTH != 0) begin : g_width_check
        $error("input_loader: LD_DATA_WIDTH must be a multiple of IN_WIDTH");
    end

    ld_state_e                state_q, state_d;
    logic [LD_ADDR_WIDTH-1:0] addr_q;
    logic [LD_ADDR_WIDTH:0]   left_q;
    logic                     wr_en_q, done_q;
    logic [LD_ADDR_WIDTH-1:0] wr_addr_q;
    logic [LD_DATA_WIDTH-1:0] wr_data_q;

    logic                     ready;
    logic                     accept;
    logic                     clear;
    logic                     word_done;
    logic                     last_word;
    logic                     start_idle;
    logic [LD_DATA_WIDTH-1:0] word;

    assign accept     = s.s_valid && ready;
    assign last_word  = word_done && (left_q == ONE_WORD);
    assign start_idle = (state_q == LD_IDLE) && start;
    assign clear      = (state_q != LD_LOAD) || abort;

    lane_packer #(
        .IN_WIDTH (IN_WIDTH),
        .PACK     (PACK),
        .LANE_W   (LANE_W)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .clear     (clear),
        .elem      (s.s_data),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LD_IDLE: if (start && num_words != '0) state_d = LD_LOAD;
            LD_LOAD: begin
                if (abort) begin
                    state_d = LD_IDLE;
                end else if (last_word) begin
                    state_d = LD_LAST;
                end
            end
            LD_LAST: state_d = LD_IDLE;
            default: state_d = LD_IDLE;
        endcase
    end

    // Abort masks ready so an element offered in the abort cycle stays with the source.
    always_comb begin
        ready = (state_q == LD_LOAD) && !abort;
        busy  = (state_q != LD_IDLE);
    end

    assign s.s_ready = ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            left_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            wr_en_q <= word_done;
            done_q  <= (start_idle && num_words == '0) || last_word;
            if (word_done) begin
                wr_addr_q <= addr_q;
                wr_data_q <= word;
                addr_q    <= addr_q + 1'b1;
                left_q    <= left_q - 1'b1;
            end
            if (start_idle) begin
                addr_q <= base_addr;
                left_q <= num_words;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;

endmodule

// File: tb/tb_input_loader.sv
// Scoreboard bench for input_loader: stimulus pushes expected writes, a
// negedge monitor pops and compares whenever wr_en or done is seen.
module tb_input_loader;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_words = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;

    input_loader_if #(.IN_WIDTH(IW)) sif ();

    input_loader #(
        .LD_DATA_WIDTH (DW),
        .LD_ADDR_WIDTH (AW),
        .IN_WIDTH      (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .num_words (num_words),
        .s         (sif),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        bit          dn;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (wr_en === 1'b1 || done === 1'b1)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got wr_en=%0b done=%0b addr=%0h data=%0h expected nothing (cycle %0d)",
                         wr_en, done, wr_addr, wr_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_en", wr_en, mon_e.wr);
                chk("done", done, mon_e.dn);
                chk("out_cycle", cyc, mon_e.cyc);
                if (mon_e.wr) begin
                    chk("wr_addr", wr_addr, mon_e.addr);
                    chk("wr_data", wr_data, mon_e.data);
                end
            end
        end
    end

    task automatic do_start(input logic [7:0] b, input int n);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = b;
        num_words = 9'(n);
        @(negedge clk);
        if (n == 0) exp_q.push_back('{1'b0, 8'h00, 32'h0, 1'b1, cyc + 1});
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = 8'hA5;
        num_words = 9'd3;
    endtask

    // Reference: word w holds elements 4w..4w+3 little-endian, address (base+w) mod 256,
    // written the cycle after its 4th element is accepted; the last word carries done.
    // gap: 0 back-to-back, 1 valid every other cycle, 2 random idle cycles.
    task automatic feed(input logic [7:0] b, input int n_words, input int n_elems,
                        input int gap, input int abort_at, input bit fixed);
        logic [31:0] word;
        logic [7:0]  e;
        int          lane;
        int          w;
        int          to;
        word = '0;
        lane = 0;
        w    = 0;
        for (int k = 0; k < n_elems; k++) begin
            e = fixed ? 8'(k + 1) : 8'($urandom);
            if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                sif.s_valid = 1'b0;
                sif.s_data  = 8'hXX;
                @(posedge clk); #1;
            end
            sif.s_valid = 1'b1;
            sif.s_data  = e;
            to = 0;
            forever begin
                @(negedge clk);
                if (sif.s_ready === 1'b1) break;
                to++;
                if (to > 50) begin
                    total++;
                    bad++;
                    $display("FAIL accept_timeout: got s_ready=%0b expected 1 within 50 cycles", sif.s_ready);
                    sif.s_valid = 1'b0;
                    return;
                end
                @(posedge clk); #1;
            end
            word[lane*8 +: 8] = e;
            if (lane == 3) begin
                exp_q.push_back('{1'b1, 8'(b + 8'(w)), word, (w == n_words - 1), cyc + 1});
                w++;
                lane = 0;
            end else begin
                lane++;
            end
            @(posedge clk); #1;
            sif.s_valid = 1'b0;
            if (w == n_words) begin
                @(negedge clk);
                chk("ready_in_last", sif.s_ready, 1'b0);
                chk("busy_in_last", busy, 1'b1);
            end
            if (k + 1 == abort_at) begin
                sif.s_valid = 1'b1;
                sif.s_data  = 8'hEE;
                abort       = 1'b1;
                @(negedge clk);
                chk("ready_during_abort", sif.s_ready, 1'b0);
                @(posedge clk); #1;
                abort       = 1'b0;
                sif.s_valid = 1'b0;
                @(negedge clk);
                chk("ready_after_abort", sif.s_ready, 1'b0);
                chk("busy_after_abort", busy, 1'b0);
                return;
            end
        end
    endtask

    task automatic settle();
        int to;
        to = 0;
        while (busy === 1'b1 && to < 50) begin
            @(posedge clk);
            to++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_idle", busy, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic run_frame(input logic [7:0] b, input int n, input int gap, input bit fixed);
        do_start(b, n);
        feed(b, n, 4 * n, gap, -1, fixed);
        settle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected finish before 300000");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 8'h00);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", sif.s_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_frame(8'h10, 2, 0, 1'b1);
        run_frame(8'h10, 2, 1, 1'b1);
        run_frame(8'hFF, 2, 0, 1'b0);

        do_start(8'h33, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("zero_busy", busy, 1'b0);
            chk("zero_ready", sif.s_ready, 1'b0);
            chk("zero_wr_en", wr_en, 1'b0);
        end
        settle();

        do_start(8'h40, 2);
        feed(8'h40, 2, 8, 0, 6, 1'b1);
        settle();
        run_frame(8'h50, 2, 0, 1'b1);

        // start pulsed while already loading must not disturb the frame
        do_start(8'h60, 2);
        start     = 1'b1;
        base_addr = 8'hAA;
        num_words = 9'd0;
        @(posedge clk); #1;
        start = 1'b0;
        feed(8'h60, 2, 8, 2, -1, 1'b0);
        settle();

        do_start(8'h20, 2);
        feed(8'h20, 2, 3, 0, -1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", wr_en, 1'b0);
        chk("midrst_wr_addr", wr_addr, 8'h00);
        chk("midrst_wr_data", wr_data, 32'h0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", sif.s_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_wr_en", wr_en, 1'b0);
            chk("postrst_busy", busy, 1'b0);
        end

        for (int f = 0; f < 6; f++) begin
            run_frame(8'($urandom), $urandom_range(1, 4), 2, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
